h14tx_encoding_multi: RTL and testbench
=======================================

Name: h14tx_encoding_multi

Overview:
- Parametrised, pipelined TMDS/TERC4 symbol encoder covering all three HDMI 1.4 channels in one block.
- Encodes `PixelsPerClk` symbols per channel per clock. Running disparity is chained across slots within a cycle, so one instance feeds a serialiser of any width.
- Adds a period-sequence checker that flags illegal period transitions.
- Sits between the period scheduler / packetiser and the serialiser; replaces per-channel encoder instances.

Parameters:
- PixelsPerClk, 1, symbols per channel per clock. Legal values 1, 2, 4.
- CheckSeq, 1, 1 builds the period-sequence checker; 0 ties seq_err to 0.

Ports:
- clk  in  1  pixel-group clock.
- rst  in  1  asynchronous, active-high reset.
- period  in  period_t  current period; applies to all slots in the cycle.
- ctl  in  [3][2]  control bits per channel; ch0 = {vsync,hsync}.
- data  in  [PixelsPerClk][3][4]  TERC4 nibbles per slot/channel.
- video  in  [PixelsPerClk][3][8]  pixel bytes per slot/channel.
- symbol  out  [PixelsPerClk][3][10]  encoded symbols; slot 0 is transmitted first.
- disparity  out  [3] signed 5  running disparity per channel after the last slot (debug).
- seq_err  out  1  one-cycle pulse, aligned with the symbol of the offending period.

Behaviour:
Reset (async, rst=1):
- Every symbol = 10'b1101010100 (control 00).
- disparity = 0, seq_err = 0, checker state = CTRL.
- Pipeline registers are cleared. Reset deasserted mid-stream restarts from this state; no partial outputs.

Latency:
- Exactly 2 clocks, input to symbol/seq_err/disparity, for every period.
- Stage 1: registers period, ctl, data; per-slot q_m[8:0] and popcounts.
- Stage 2: disparity chain, output mux, registered outputs.

Video encode (DVI 1.0 algorithm), per slot s, in order 0..PixelsPerClk-1:
- Use XNOR if n1(d) > 4, or n1(d) == 4 and d[0] == 0; otherwise XOR.
- q_m[8] = 1 for XOR, 0 for XNOR.
- cnt_in for slot 0 is the registered disparity; for slot s>0 it is the cnt_out of slot s-1.
- If cnt_in == 0 or n1(q_m[7:0]) == n0(q_m[7:0]):
  - q[9] = ~q_m[8], q[8] = q_m[8], q[7:0] = q_m[8] ? q_m : ~q_m.
  - cnt_out = cnt_in + (q_m[8] ? n1-n0 : n0-n1).
- Else if (cnt_in > 0 and n1 > n0) or (cnt_in < 0 and n0 > n1):
  - q[9] = 1, q[8] = q_m[8], q[7:0] = ~q_m.
  - cnt_out = cnt_in + 2*q_m[8] + (n0-n1).
- Else:
  - q[9] = 0, q[8] = q_m[8], q[7:0] = q_m.
  - cnt_out = cnt_in - 2*~q_m[8] + (n1-n0).
- cnt is 5-bit signed, with range -16..+15 guaranteed by the algorithm; no saturation.

Disparity:
- Registered disparity updates only in VideoActive.
- Cleared to 0 on any cycle whose period is not VideoActive.

Other periods (all slots identical except data/TERC4, which is per slot):
- Control: ch i = CTRL code of ctl[i]:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- VideoPreamble: ch0 = CTRL(ctl[0]), ch1 = CTRL(01), ch2 = CTRL(00).
- DataIslandPreamble: ch0 = CTRL(ctl[0]), ch1 = CTRL(01), ch2 = CTRL(01).
- VideoGuard: ch0 = 1011001100, ch1 = 0100110011, ch2 = 1011001100.
- DataIslandGuard: ch0 = TERC4({2'b11,ctl[0]}), ch1 = ch2 = 0100110011.
- DataIslandActive: ch i = TERC4(data[s][i]), using the standard 16-entry table, q[9:0]:
  - 0 → 1010011100
  - 7 → 0100111100
  - D → 1001110001
  - F → 1011000011
- The ctl input is ignored on ch1/ch2 outside Control.

Sequence checker: state machine, states CTRL, VPRE, VGRD, VACT, DPRE, DGLEAD, DACT, DGTRAIL.
- Legal transitions:
  - CTRL → CTRL, VPRE, DPRE
  - VPRE → VPRE, VGRD
  - VGRD → VGRD, VACT
  - VACT → VACT, CTRL
  - DPRE → DPRE, DGLEAD
  - DGLEAD → DGLEAD, DACT
  - DACT → DACT, DGTRAIL
  - DGTRAIL → DGTRAIL, CTRL
- Any other transition pulses seq_err for 1 cycle, and the state resyncs to the state implied by the new period. DataIslandGuard arriving from CTRL maps to DGLEAD.
- Consecutive guard cycles are not counted; guard length is not checked.

Decomposition:
- h14tx_pkg holds:
  - period_t, ctl_t, data_t, video_t, symbol_t
  - CTRL code constants, the TERC4 table function, video/DI guard constants
  - seq_state_t enum
- Sub-module h14tx_tmds_slot: combinational one-slot video encoder, taking q_m/cnt_in and producing q/cnt_out. It is instanced PixelsPerClk × 3 in a chain.

Test Plan:
- Reset asserted mid-VideoActive → symbols = 0x354 on all slots/channels, disparity = 0, within 0 clocks of rst rising; after release, Control with ctl = 0 → 0x354 two clocks later.
- PixelsPerClk=1, VideoActive, video ch0 = 0x00 then 0x00 from disparity 0:
  - 1st symbol = 10'b0100000000, disparity = -8.
  - 2nd symbol = 10'b1111111111, disparity = +2.
  - Then 0xFF from a fresh Control gives 10'b1000000000, disparity = -8.
- PixelsPerClk=2, first VideoActive cycle, both slots 0x00 → slot0 = 10'b0100000000, slot1 = 10'b1111111111, disparity = +2 (chain matches serial result).
- Full data-island sequence Control→DPRE→DGLEAD→DACT(data ch0 = 0x7, ch1 = 0xD)→DGTRAIL→Control:
  - DPRE: ch1/ch2 = 0x0AB.
  - DACT: ch0 = 0100111100, ch1 = 1001110001.
  - No seq_err; every output appears 2 clocks after its input.
- Illegal VideoActive directly after Control → seq_err = 1 for exactly one cycle, 2 clocks later. A following legal VideoActive gives seq_err = 0.
- Control cycles ctl ch0 = 10, 01, 11 → 0101010100, 0010101011, 1010101011; VideoGuard → ch0/ch1/ch2 = 1011001100/0100110011/1011001100.

Source files
------------

// File: rtl/h14tx_pkg.sv
// Shared types, symbol constants and encoding helpers for the HDMI 1.4 TX
// TMDS/TERC4 encoder.
package h14tx_pkg;

  typedef enum logic [2:0] {
    PER_CONTROL,
    PER_VIDEO_PRE,
    PER_VIDEO_GUARD,
    PER_VIDEO_ACTIVE,
    PER_DI_PRE,
    PER_DI_GUARD,
    PER_DI_ACTIVE
  } period_t;

  typedef logic [2:0][1:0] ctl_t;     // per channel; ch0 = {vsync,hsync}
  typedef logic [2:0][3:0] data_t;    // one slot, TERC4 nibble per channel
  typedef logic [2:0][7:0] video_t;   // one slot, pixel byte per channel
  typedef logic [2:0][9:0] symbol_t;  // one slot, 10-bit symbol per channel
  typedef logic signed [4:0] disp_t;  // running disparity

  typedef enum logic [2:0] {
    SEQ_CTRL,
    SEQ_VPRE,
    SEQ_VGRD,
    SEQ_VACT,
    SEQ_DPRE,
    SEQ_DGLEAD,
    SEQ_DACT,
    SEQ_DGTRAIL
  } seq_state_t;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] VGUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] VGUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] VGUARD_CH2 = 10'b1011001100;
  localparam logic [9:0] DGUARD_CH12 = 10'b0100110011;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL_00;
      2'b01:   return CTRL_01;
      2'b10:   return CTRL_10;
      default: return CTRL_11;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    case (d)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++)
      n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Transition-minimising first stage: q_m[8] = 1 marks the XOR variant.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] ones;
    logic       use_xnor;
    logic [8:0] qm;
    ones     = popcount8(d);
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int unsigned i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return qm;
  endfunction

endpackage

// File: rtl/h14tx_tmds_slot.sv
// Combinational DC-balancing stage of the TMDS video encoder for one slot of
// one channel: takes q_m and its popcount plus the incoming disparity and
// produces the 10-bit symbol and the outgoing disparity.
module h14tx_tmds_slot
  import h14tx_pkg::*;
(
  input  logic [8:0] q_m,
  input  logic [3:0] n1,
  input  disp_t      cnt_in,
  output logic [9:0] q,
  output disp_t      cnt_out
);

  logic signed [5:0] diff;  // n1 - n0 of q_m[7:0]
  logic signed [5:0] cin6;
  logic signed [5:0] acc;

  // Choose inversion to steer running disparity toward zero.
  always_comb begin
    diff = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    cin6 = {cnt_in[4], cnt_in};
    q    = '0;
    acc  = cin6;
    if ((cnt_in == 5'sd0) || (diff == 6'sd0)) begin
      q   = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      acc = q_m[8] ? (cin6 + diff) : (cin6 - diff);
    end else if ((!cnt_in[4] && (diff > 6'sd0)) || (cnt_in[4] && (diff < 6'sd0))) begin
      q   = {1'b1, q_m[8], ~q_m[7:0]};
      acc = cin6 + (q_m[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      q   = {1'b0, q_m[8], q_m[7:0]};
      acc = cin6 - (q_m[8] ? 6'sd0 : 6'sd2) + diff;
    end
    cnt_out = acc[4:0];
  end

endmodule

// File: rtl/h14tx_encoding_multi.sv
// Three-channel HDMI 1.4 TMDS/TERC4 encoder, PixelsPerClk symbols per channel
// per clock, two-stage pipeline, with an optional period-sequence checker.
module h14tx_encoding_multi
  import h14tx_pkg::*;
#(
  parameter int unsigned PixelsPerClk = 1,
  parameter bit          CheckSeq     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  period_t                    period,
  input  ctl_t                       ctl,
  input  data_t   [PixelsPerClk-1:0] data,
  input  video_t  [PixelsPerClk-1:0] video,
  output symbol_t [PixelsPerClk-1:0] symbol,
  output disp_t   [2:0]              disparity,
  output logic                       seq_err
);

  // ---------------- stage 1 ----------------
  period_t                               p1_period;
  ctl_t                                  p1_ctl;
  data_t [PixelsPerClk-1:0]              p1_data;
  logic  [PixelsPerClk-1:0][2:0][8:0]    p1_qm;
  logic  [PixelsPerClk-1:0][2:0][3:0]    p1_n1;
  logic  [PixelsPerClk-1:0][2:0][8:0]    s1_qm;
  logic  [PixelsPerClk-1:0][2:0][3:0]    s1_n1;

  // Per-slot transition minimisation and popcount, ahead of the register.
  always_comb begin
    s1_qm = '0;
    s1_n1 = '0;
    for (int unsigned s = 0; s < PixelsPerClk; s++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        s1_qm[s][c] = tmds_qm(video[s][c]);
        s1_n1[s][c] = popcount8(s1_qm[s][c][7:0]);
      end
    end
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_period <= PER_CONTROL;
      p1_ctl    <= '0;
      p1_data   <= '0;
      p1_qm     <= '0;
      p1_n1     <= '0;
    end else begin
      p1_period <= period;
      p1_ctl    <= ctl;
      p1_data   <= data;
      p1_qm     <= s1_qm;
      p1_n1     <= s1_n1;
    end
  end

  // ---------------- stage 2 ----------------
  // Disparity ripples slot 0 -> slot N-1 within a cycle, so each slot sees
  // the balance left by the one transmitted before it.
  disp_t                    chain [PixelsPerClk+1][3];
  logic  [9:0]              vid_q [PixelsPerClk][3];
  symbol_t [PixelsPerClk-1:0] sym_d;
  disp_t   [2:0]              disp_d;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign chain[0][c] = disparity[c];
    for (genvar s = 0; s < PixelsPerClk; s++) begin : g_slot
      h14tx_tmds_slot u_slot (
        .q_m    (p1_qm[s][c]),
        .n1     (p1_n1[s][c]),
        .cnt_in (chain[s][c]),
        .q      (vid_q[s][c]),
        .cnt_out(chain[s+1][c])
      );
    end
  end

  // Output symbol selection by period, plus next disparity.
  always_comb begin
    sym_d  = '0;
    disp_d = '0;
    for (int unsigned s = 0; s < PixelsPerClk; s++) begin
      case (p1_period)
        PER_CONTROL: begin
          sym_d[s][0] = ctrl_code(p1_ctl[0]);
          sym_d[s][1] = ctrl_code(p1_ctl[1]);
          sym_d[s][2] = ctrl_code(p1_ctl[2]);
        end
        PER_VIDEO_PRE: begin
          sym_d[s][0] = ctrl_code(p1_ctl[0]);
          sym_d[s][1] = CTRL_01;
          sym_d[s][2] = CTRL_00;
        end
        PER_VIDEO_GUARD: begin
          sym_d[s][0] = VGUARD_CH0;
          sym_d[s][1] = VGUARD_CH1;
          sym_d[s][2] = VGUARD_CH2;
        end
        PER_VIDEO_ACTIVE: begin
          sym_d[s][0] = vid_q[s][0];
          sym_d[s][1] = vid_q[s][1];
          sym_d[s][2] = vid_q[s][2];
        end
        PER_DI_PRE: begin
          sym_d[s][0] = ctrl_code(p1_ctl[0]);
          sym_d[s][1] = CTRL_01;
          sym_d[s][2] = CTRL_01;
        end
        PER_DI_GUARD: begin
          sym_d[s][0] = terc4({2'b11, p1_ctl[0]});
          sym_d[s][1] = DGUARD_CH12;
          sym_d[s][2] = DGUARD_CH12;
        end
        PER_DI_ACTIVE: begin
          sym_d[s][0] = terc4(p1_data[s][0]);
          sym_d[s][1] = terc4(p1_data[s][1]);
          sym_d[s][2] = terc4(p1_data[s][2]);
        end
        default: begin
          sym_d[s][0] = CTRL_00;
          sym_d[s][1] = CTRL_00;
          sym_d[s][2] = CTRL_00;
        end
      endcase
    end
    for (int unsigned c = 0; c < 3; c++)
      disp_d[c] = (p1_period == PER_VIDEO_ACTIVE) ? chain[PixelsPerClk][c] : 5'sd0;
  end

  // Stage-2 output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      symbol    <= {(3*PixelsPerClk){CTRL_00}};
      disparity <= '0;
    end else begin
      symbol    <= sym_d;
      disparity <= disp_d;
    end
  end

  // ---------------- period-sequence checker ----------------
  if (CheckSeq) begin : g_seq
    seq_state_t state_q;
    seq_state_t state_d;
    logic       legal;

    // Checker state and error pulse, aligned with the stage-2 outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= SEQ_CTRL;
        seq_err <= 1'b0;
      end else begin
        state_q <= state_d;
        seq_err <= ~legal;
      end
    end

    // The next state is always the one implied by the period (so illegal
    // transitions resync); legality is then judged on that pair. A guard
    // period is a trailing guard only when it follows island data.
    always_comb begin
      state_d = SEQ_CTRL;
      legal   = 1'b0;
      case (p1_period)
        PER_CONTROL:      state_d = SEQ_CTRL;
        PER_VIDEO_PRE:    state_d = SEQ_VPRE;
        PER_VIDEO_GUARD:  state_d = SEQ_VGRD;
        PER_VIDEO_ACTIVE: state_d = SEQ_VACT;
        PER_DI_PRE:       state_d = SEQ_DPRE;
        PER_DI_GUARD:     state_d = ((state_q == SEQ_DACT) || (state_q == SEQ_DGTRAIL))
                                    ? SEQ_DGTRAIL : SEQ_DGLEAD;
        PER_DI_ACTIVE:    state_d = SEQ_DACT;
        default:          state_d = SEQ_CTRL;
      endcase
      case (state_q)
        SEQ_CTRL:    legal = (state_d == SEQ_CTRL) || (state_d == SEQ_VPRE) || (state_d == SEQ_DPRE);
        SEQ_VPRE:    legal = (state_d == SEQ_VPRE) || (state_d == SEQ_VGRD);
        SEQ_VGRD:    legal = (state_d == SEQ_VGRD) || (state_d == SEQ_VACT);
        SEQ_VACT:    legal = (state_d == SEQ_VACT) || (state_d == SEQ_CTRL);
        SEQ_DPRE:    legal = (state_d == SEQ_DPRE) || (state_d == SEQ_DGLEAD);
        SEQ_DGLEAD:  legal = (state_d == SEQ_DGLEAD) || (state_d == SEQ_DACT);
        SEQ_DACT:    legal = (state_d == SEQ_DACT) || (state_d == SEQ_DGTRAIL);
        SEQ_DGTRAIL: legal = (state_d == SEQ_DGTRAIL) || (state_d == SEQ_CTRL);
        default:     legal = 1'b0;
      endcase
    end
  end else begin : g_noseq
    assign seq_err = 1'b0;
  end

endmodule

// File: tb/tb_h14tx_encoding_multi.sv
// Directed testbench for h14tx_encoding_multi: one 1-slot and one 2-slot
// instance driven with the same period/control stream.
module tb_h14tx_encoding_multi;
  import h14tx_pkg::*;

  typedef struct {
    period_t    p;
    logic [1:0] c;
    logic [7:0] v;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [9:0] e2;
    logic [4:0] ed;
    logic       ee;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  period_t period;
  ctl_t    ctl;

  data_t   [0:0] data1;
  video_t  [0:0] video1;
  symbol_t [0:0] sym1;
  disp_t   [2:0] disp1;
  logic          err1;

  data_t   [1:0] data2;
  video_t  [1:0] video2;
  symbol_t [1:0] sym2;
  disp_t   [2:0] disp2;
  logic          err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  h14tx_encoding_multi #(.PixelsPerClk(1), .CheckSeq(1'b1)) dut (
    .clk(clk), .rst(rst), .period(period), .ctl(ctl), .data(data1), .video(video1),
    .symbol(sym1), .disparity(disp1), .seq_err(err1)
  );

  h14tx_encoding_multi #(.PixelsPerClk(2), .CheckSeq(1'b1)) dut2 (
    .clk(clk), .rst(rst), .period(period), .ctl(ctl), .data(data2), .video(video2),
    .symbol(sym2), .disparity(disp2), .seq_err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input period_t p, input logic [1:0] c, input logic [7:0] v,
                       input logic [3:0] d0, input logic [3:0] d1);
    period = p;
    ctl    = {c, c, c};
    video1 = {3{v}};
    video2 = {6{v}};
    data1  = {4'h0, d1, d0};
    data2  = {2{4'h0, d1, d0}};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    period = PER_CONTROL;
    ctl = '0; data1 = '0; data2 = '0; video1 = '0; video2 = '0;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (sym1[0][c] !== 10'b1101010100) begin
        errors++; $display("FAIL reset_sym ch%0d got %b exp %b", c, sym1[0][c], 10'b1101010100);
      end
      checks++;
      if (disp1[c] !== 5'd0) begin
        errors++; $display("FAIL reset_disp ch%0d got %0d exp 0", c, disp1[c]);
      end
    end
    checks++;
    if (err1 !== 1'b0) begin
      errors++; $display("FAIL reset_seq_err got %b exp 0", err1);
    end
    rst = 1'b0;
  endtask

  task automatic test_video();
    vec_t tv [10];
    tv = '{
      '{PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_VIDEO_PRE,    2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b0010101011, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_VIDEO_GUARD,  2'b00, 8'h00, 4'h0, 4'h0, 10'b1011001100, 10'b0100110011, 10'b1011001100, 5'b00000, 1'b0},
      '{PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0, 10'b0100000000, 10'b0100000000, 10'b0100000000, 5'b11000, 1'b0},
      '{PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0, 10'b1111111111, 10'b1111111111, 10'b1111111111, 5'b00010, 1'b0},
      '{PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_VIDEO_PRE,    2'b00, 8'hFF, 4'h0, 4'h0, 10'b1101010100, 10'b0010101011, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_VIDEO_GUARD,  2'b00, 8'hFF, 4'h0, 4'h0, 10'b1011001100, 10'b0100110011, 10'b1011001100, 5'b00000, 1'b0},
      '{PER_VIDEO_ACTIVE, 2'b00, 8'hFF, 4'h0, 4'h0, 10'b1000000000, 10'b1000000000, 10'b1000000000, 5'b11000, 1'b0},
      '{PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0}
    };
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) apply(tv[i].p, tv[i].c, tv[i].v, tv[i].d0, tv[i].d1);
      else tick();
      if (i >= 1) begin
        int j;
        j = i - 1;
        checks++;
        if (sym1[0][0] !== tv[j].e0) begin errors++; $display("FAIL video_ch0 vec %0d got %b exp %b", j, sym1[0][0], tv[j].e0); end
        checks++;
        if (sym1[0][1] !== tv[j].e1) begin errors++; $display("FAIL video_ch1 vec %0d got %b exp %b", j, sym1[0][1], tv[j].e1); end
        checks++;
        if (sym1[0][2] !== tv[j].e2) begin errors++; $display("FAIL video_ch2 vec %0d got %b exp %b", j, sym1[0][2], tv[j].e2); end
        checks++;
        if (disp1[0] !== tv[j].ed) begin errors++; $display("FAIL video_disp vec %0d got %b exp %b", j, disp1[0], tv[j].ed); end
        checks++;
        if (err1 !== tv[j].ee) begin errors++; $display("FAIL video_seq_err vec %0d got %b exp %b", j, err1, tv[j].ee); end
        if (j == 3) begin
          checks++;
          if (sym2[0][0] !== 10'b0100000000) begin errors++; $display("FAIL chain_slot0 got %b exp %b", sym2[0][0], 10'b0100000000); end
          checks++;
          if (sym2[1][0] !== 10'b1111111111) begin errors++; $display("FAIL chain_slot1 got %b exp %b", sym2[1][0], 10'b1111111111); end
          checks++;
          if (disp2[0] !== 5'b00010) begin errors++; $display("FAIL chain_disp got %b exp %b", disp2[0], 5'b00010); end
        end
      end
    end
  endtask

  task automatic test_data_island();
    vec_t tv [6];
    tv = '{
      '{PER_CONTROL,   2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_DI_PRE,    2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b0010101011, 10'b0010101011, 5'b00000, 1'b0},
      '{PER_DI_GUARD,  2'b00, 8'h00, 4'h0, 4'h0, 10'b1010001110, 10'b0100110011, 10'b0100110011, 5'b00000, 1'b0},
      '{PER_DI_ACTIVE, 2'b00, 8'h00, 4'h7, 4'hD, 10'b0100111100, 10'b1001110001, 10'b1010011100, 5'b00000, 1'b0},
      '{PER_DI_GUARD,  2'b00, 8'h00, 4'h0, 4'h0, 10'b1010001110, 10'b0100110011, 10'b0100110011, 5'b00000, 1'b0},
      '{PER_CONTROL,   2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0}
    };
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) apply(tv[i].p, tv[i].c, tv[i].v, tv[i].d0, tv[i].d1);
      else tick();
      if (i >= 1) begin
        int j;
        j = i - 1;
        checks++;
        if (sym1[0][0] !== tv[j].e0) begin errors++; $display("FAIL di_ch0 vec %0d got %b exp %b", j, sym1[0][0], tv[j].e0); end
        checks++;
        if (sym1[0][1] !== tv[j].e1) begin errors++; $display("FAIL di_ch1 vec %0d got %b exp %b", j, sym1[0][1], tv[j].e1); end
        checks++;
        if (sym1[0][2] !== tv[j].e2) begin errors++; $display("FAIL di_ch2 vec %0d got %b exp %b", j, sym1[0][2], tv[j].e2); end
        checks++;
        if (sym2[1][1] !== tv[j].e1) begin errors++; $display("FAIL di_slot1_ch1 vec %0d got %b exp %b", j, sym2[1][1], tv[j].e1); end
        checks++;
        if (err1 !== tv[j].ee) begin errors++; $display("FAIL di_seq_err vec %0d got %b exp %b", j, err1, tv[j].ee); end
      end
    end
  endtask

  task automatic test_seq_err();
    vec_t tv [5];
    tv = '{
      '{PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0, 10'b0100000000, 10'b0100000000, 10'b0100000000, 5'b11000, 1'b1},
      '{PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0, 10'b1111111111, 10'b1111111111, 10'b1111111111, 5'b00010, 1'b0},
      '{PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0}
    };
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) apply(tv[i].p, tv[i].c, tv[i].v, tv[i].d0, tv[i].d1);
      else tick();
      if (i >= 1) begin
        int j;
        j = i - 1;
        checks++;
        if (err1 !== tv[j].ee) begin errors++; $display("FAIL seq_err vec %0d got %b exp %b", j, err1, tv[j].ee); end
        checks++;
        if (err2 !== tv[j].ee) begin errors++; $display("FAIL seq_err_p2 vec %0d got %b exp %b", j, err2, tv[j].ee); end
        checks++;
        if (sym1[0][0] !== tv[j].e0) begin errors++; $display("FAIL seq_sym vec %0d got %b exp %b", j, sym1[0][0], tv[j].e0); end
        checks++;
        if (disp1[0] !== tv[j].ed) begin errors++; $display("FAIL seq_disp vec %0d got %b exp %b", j, disp1[0], tv[j].ed); end
      end
    end
  endtask

  task automatic test_control_guard();
    vec_t tv [7];
    tv = '{
      '{PER_CONTROL,      2'b10, 8'h00, 4'h0, 4'h0, 10'b0101010100, 10'b0101010100, 10'b0101010100, 5'b00000, 1'b0},
      '{PER_CONTROL,      2'b01, 8'h00, 4'h0, 4'h0, 10'b0010101011, 10'b0010101011, 10'b0010101011, 5'b00000, 1'b0},
      '{PER_CONTROL,      2'b11, 8'h00, 4'h0, 4'h0, 10'b1010101011, 10'b1010101011, 10'b1010101011, 5'b00000, 1'b0},
      '{PER_VIDEO_PRE,    2'b11, 8'h00, 4'h0, 4'h0, 10'b1010101011, 10'b0010101011, 10'b1101010100, 5'b00000, 1'b0},
      '{PER_VIDEO_GUARD,  2'b11, 8'h00, 4'h0, 4'h0, 10'b1011001100, 10'b0100110011, 10'b1011001100, 5'b00000, 1'b0},
      '{PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0, 10'b0100000000, 10'b0100000000, 10'b0100000000, 5'b11000, 1'b0},
      '{PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0, 10'b1101010100, 10'b1101010100, 10'b1101010100, 5'b00000, 1'b0}
    };
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) apply(tv[i].p, tv[i].c, tv[i].v, tv[i].d0, tv[i].d1);
      else tick();
      if (i >= 1) begin
        int j;
        j = i - 1;
        checks++;
        if (sym1[0][0] !== tv[j].e0) begin errors++; $display("FAIL ctl_ch0 vec %0d got %b exp %b", j, sym1[0][0], tv[j].e0); end
        checks++;
        if (sym1[0][1] !== tv[j].e1) begin errors++; $display("FAIL ctl_ch1 vec %0d got %b exp %b", j, sym1[0][1], tv[j].e1); end
        checks++;
        if (sym1[0][2] !== tv[j].e2) begin errors++; $display("FAIL ctl_ch2 vec %0d got %b exp %b", j, sym1[0][2], tv[j].e2); end
        checks++;
        if (err1 !== tv[j].ee) begin errors++; $display("FAIL ctl_seq_err vec %0d got %b exp %b", j, err1, tv[j].ee); end
        if (tv[j].p != PER_VIDEO_ACTIVE) begin
          checks++;
          if (sym2[1][2] !== tv[j].e2) begin errors++; $display("FAIL ctl_slot1_ch2 vec %0d got %b exp %b", j, sym2[1][2], tv[j].e2); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(PER_CONTROL,      2'b00, 8'h00, 4'h0, 4'h0);
    apply(PER_VIDEO_PRE,    2'b00, 8'h00, 4'h0, 4'h0);
    apply(PER_VIDEO_GUARD,  2'b00, 8'h00, 4'h0, 4'h0);
    apply(PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0);
    apply(PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0);
    apply(PER_VIDEO_ACTIVE, 2'b00, 8'h00, 4'h0, 4'h0);
    checks++;
    if (sym1[0][0] !== 10'b1111111111) begin
      errors++; $display("FAIL pre_reset_sym got %b exp %b", sym1[0][0], 10'b1111111111);
    end
    #2 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (sym1[0][c] !== 10'b1101010100) begin
        errors++; $display("FAIL midrst_sym ch%0d got %b exp %b", c, sym1[0][c], 10'b1101010100);
      end
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (sym2[s][c] !== 10'b1101010100) begin
          errors++; $display("FAIL midrst_sym_p2 s%0d ch%0d got %b exp %b", s, c, sym2[s][c], 10'b1101010100);
        end
      end
      checks++;
      if (disp1[c] !== 5'd0) begin
        errors++; $display("FAIL midrst_disp ch%0d got %0d exp 0", c, disp1[c]);
      end
    end
    period = PER_CONTROL;
    ctl = '0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (sym1[0][0] !== 10'b1101010100) begin
      errors++; $display("FAIL postrst_sym got %b exp %b", sym1[0][0], 10'b1101010100);
    end
    checks++;
    if (err1 !== 1'b0) begin
      errors++; $display("FAIL postrst_seq_err got %b exp 0", err1);
    end
  endtask

  initial begin
    test_reset();
    test_video();
    test_data_island();
    test_seq_err();
    test_control_guard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
